// File: rtl/byte_cpu_system_pkg.sv
// rtl/byte_cpu_system_pkg.sv - shared constants, opcodes and CPU state encoding
// Purpose: default memory address width, ISA opcode values, FSM state enum and
// a decode helper used by the byte_cpu_system top.
package byte_cpu_system_pkg;

    localparam int AW_DEF = 18;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_LDI  = 8'h01;
    localparam logic [7:0] OP_LD   = 8'h02;
    localparam logic [7:0] OP_ST   = 8'h03;
    localparam logic [7:0] OP_ADD  = 8'h04;
    localparam logic [7:0] OP_SUB  = 8'h05;
    localparam logic [7:0] OP_JMP  = 8'h06;
    localparam logic [7:0] OP_JZ   = 8'h07;
    localparam logic [7:0] OP_SHR  = 8'h08;
    localparam logic [7:0] OP_HALT = 8'hFF;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_OPND0,
        ST_OPND1,
        ST_OPND2,
        ST_EXEC,
        ST_WB,
        ST_DONE
    } cpu_state_e;

    // LDI through JZ form one contiguous opcode range that carries operand bytes.
    function automatic logic has_operands(input logic [7:0] op);
        return (op >= OP_LDI) && (op <= OP_JZ);
    endfunction

endpackage

// File: rtl/byte_cpu_system_if.sv
// rtl/byte_cpu_system_if.sv - host programming / control bundle for byte_cpu_system
// Signals: startProgram (run permit), programAddress/programByte/programWrEn
// (host byte write port), PC_out (done flag from the CPU).
// master = host side, slave = CPU subsystem side.
interface byte_cpu_system_if;

    logic        startProgram;
    logic [31:0] programAddress;
    logic [7:0]  programByte;
    logic        programWrEn;
    logic        PC_out;

    modport master (
        output startProgram,
        output programAddress,
        output programByte,
        output programWrEn,
        input  PC_out
    );

    modport slave (
        input  startProgram,
        input  programAddress,
        input  programByte,
        input  programWrEn,
        output PC_out
    );

endinterface

// File: rtl/byte_cpu_system_byte_ram.sv
// rtl/byte_cpu_system_byte_ram.sv - single-clock 1R1W byte memory, synchronous read
// Ports: clk; re_i/raddr_i -> rdata_o (valid the cycle after the address, held
// while re_i=0); we_i/waddr_i/wdata_i write port. Contents are never reset.
module byte_cpu_system_byte_ram #(
    parameter int AW = 18,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        // Holding the read register while idle keeps already-fetched bytes stable
        // across CPU stalls, even if the host rewrites that location.
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/byte_cpu_system.sv
// rtl/byte_cpu_system.sv - 8-bit accumulator CPU with unified byte memory and host load port
// Ports: clk; reset (async, active-low); bus (slave modport) carrying
// startProgram, programAddress, programByte, programWrEn in and PC_out out.
module byte_cpu_system
    import byte_cpu_system_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = 8
) (
    input  logic             clk,
    input  logic             reset,
    byte_cpu_system_if.slave bus
);

    // Bits of the third operand byte that land inside the address space.
    localparam int HI = AW - 16;

    cpu_state_e    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [7:0]    op_q, op_d;
    logic [15:0]   lo_q, lo_d;

    logic          run;
    logic [DW-1:0] rd_data;
    logic          ram_we;
    logic          host_we;
    logic          cpu_we;
    logic [AW-1:0] ram_raddr;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_wdata;
    logic [AW-1:0] opnd_addr;

    // CPU only advances (and only touches memory) while released and the host is idle.
    assign run = bus.startProgram & ~bus.programWrEn;

    // In EXEC the read register holds the third operand byte.
    assign opnd_addr = {rd_data[HI-1:0], lo_q};

    // Host addresses beyond the memory are dropped rather than aliased.
    assign host_we   = bus.programWrEn && (bus.programAddress[31:AW] == '0);
    assign ram_we    = host_we | cpu_we;
    assign ram_waddr = bus.programWrEn ? bus.programAddress[AW-1:0] : opnd_addr;
    assign ram_wdata = bus.programWrEn ? bus.programByte : acc_q;

    byte_cpu_system_byte_ram #(
        .AW (AW),
        .DW (DW)
    ) u_ram (
        .clk     (clk),
        .re_i    (run),
        .raddr_i (ram_raddr),
        .rdata_o (rd_data),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata)
    );

    // State register: everything freezes while the run gate is closed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            acc_q   <= '0;
            op_q    <= '0;
            lo_q    <= '0;
        end else if (run) begin
            state_q <= state_d;
            pc_q    <= pc_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            lo_q    <= lo_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                if (rd_data == OP_HALT) begin
                    state_d = ST_DONE;
                end else if (has_operands(rd_data)) begin
                    state_d = ST_OPND0;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_OPND0:  state_d = (op_q == OP_LDI) ? ST_EXEC : ST_OPND1;
            ST_OPND1:  state_d = ST_OPND2;
            ST_OPND2:  state_d = ST_EXEC;
            ST_EXEC: begin
                if (op_q == OP_LD || op_q == OP_ADD || op_q == OP_SUB) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_WB:     state_d = ST_FETCH;
            ST_DONE:   state_d = ST_DONE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Datapath updates and memory controls.
    always_comb begin
        pc_d      = pc_q;
        acc_d     = acc_q;
        op_d      = op_q;
        lo_d      = lo_q;
        ram_raddr = pc_q;
        cpu_we    = 1'b0;
        bus.PC_out = (state_q == ST_DONE);
        case (state_q)
            ST_DECODE: begin
                op_d = rd_data;
                pc_d = pc_q + AW'(1);
                case (rd_data)
                    OP_SHR:  acc_d = acc_q >> 1;
                    OP_NOP:  acc_d = acc_q;
                    default: acc_d = acc_q;
                endcase
            end
            ST_OPND0: pc_d = pc_q + AW'(1);
            ST_OPND1: begin
                lo_d[7:0] = rd_data;
                pc_d      = pc_q + AW'(1);
            end
            ST_OPND2: begin
                lo_d[15:8] = rd_data;
                pc_d       = pc_q + AW'(1);
            end
            ST_EXEC: begin
                ram_raddr = opnd_addr;
                case (op_q)
                    OP_LDI:  acc_d  = rd_data;
                    OP_ST:   cpu_we = run;
                    OP_JMP:  pc_d   = opnd_addr;
                    OP_JZ:   if (acc_q == '0) pc_d = opnd_addr;
                    default: ;
                endcase
            end
            ST_WB: begin
                case (op_q)
                    OP_LD:   acc_d = rd_data;
                    OP_ADD:  acc_d = acc_q + rd_data;
                    OP_SUB:  acc_d = acc_q - rd_data;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_byte_cpu_system.sv
// tb/tb_byte_cpu_system.sv - self-checking bench for byte_cpu_system with an ISA-level reference model
module tb_byte_cpu_system;
    import byte_cpu_system_pkg::*;

    localparam int MASK = (1 << 18) - 1;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   exp_cyc;

    logic [7:0] prog[$];
    logic [7:0] mm[int];
    int         pool[$];

    byte_cpu_system_if bus();

    byte_cpu_system dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mrd(input int a);
        return mm.exists(a) ? mm[a] : 8'h00;
    endfunction

    function automatic logic [7:0] dmem(input int a);
        logic [17:0] idx;
        idx = a[17:0];
        return dut.u_ram.mem_q[idx];
    endfunction

    // Instruction-level interpreter: executes the ISA directly on the model memory
    // and sums the documented per-instruction cycle costs.
    task automatic model_run(output int cyc);
        int         pc;
        int         a;
        logic [7:0] acc;
        logic [7:0] op;
        bit         halted;
        pc = 0; acc = 8'h00; halted = 0; cyc = 0;
        for (int s = 0; s < 500 && !halted; s++) begin
            op = mrd(pc);
            pc = (pc + 1) & MASK;
            if (op == 8'h01) begin
                acc = mrd(pc);
                pc  = (pc + 1) & MASK;
                cyc += 4;
            end else if (op >= 8'h02 && op <= 8'h07) begin
                a  = int'({8'h00, mrd((pc + 2) & MASK), mrd((pc + 1) & MASK), mrd(pc)}) & MASK;
                pc = (pc + 3) & MASK;
                case (op)
                    8'h02: begin acc = mrd(a);       cyc += 7; end
                    8'h03: begin mm[a] = acc;        cyc += 6; end
                    8'h04: begin acc = acc + mrd(a); cyc += 7; end
                    8'h05: begin acc = acc - mrd(a); cyc += 7; end
                    8'h06: begin pc = a;             cyc += 6; end
                    default: begin if (acc == 8'h00) pc = a; cyc += 6; end
                endcase
            end else if (op == 8'h08) begin
                acc = acc >> 1;
                cyc += 2;
            end else if (op == 8'hFF) begin
                halted = 1;
                cyc += 2;
            end else begin
                cyc += 2;
            end
        end
    endtask

    task automatic host_wr(input logic [31:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.programWrEn    = 1'b1;
        bus.programAddress = a;
        bus.programByte    = d;
        if (a <= 32'(MASK)) mm[int'(a)] = d;
    endtask

    task automatic host_end();
        @(negedge clk);
        bus.programWrEn = 1'b0;
    endtask

    task automatic load(input bit dir, input logic [7:0] v256, input logic [7:0] v257);
        @(negedge clk);
        reset = 1'b0;
        bus.startProgram = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        mm.delete();
        foreach (prog[i]) host_wr(32'(i), prog[i]);
        foreach (pool[i]) host_wr(32'(pool[i]), 8'($urandom));
        if (dir) begin
            host_wr(32'd256, v256);
            host_wr(32'd257, v257);
        end
        host_end();
        model_run(exp_cyc);
    endtask

    // Runs the CPU, counting clock edges on which the run gate is open, until PC_out
    // is seen, the abort point is reached, or the cycle limit expires.
    task automatic run_dut(input int limit, input int stall_at, input int stall_len,
                           input bit stall_wr, input logic [31:0] sa, input logic [7:0] sb,
                           input int abort_at, output int gated, output bit done);
        int left;
        bit started;
        gated = 0; done = 0; left = 0; started = 0;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            if (bus.PC_out === 1'b1) begin
                done = 1;
                break;
            end
            if (abort_at >= 0 && gated == abort_at) break;
            if (!started && gated == stall_at) begin
                started = 1;
                left    = stall_len;
            end
            if (left > 0) begin
                left--;
                bus.startProgram   = stall_wr;
                bus.programWrEn    = stall_wr;
                bus.programAddress = sa;
                bus.programByte    = sb;
            end else begin
                bus.startProgram = 1'b1;
                bus.programWrEn  = 1'b0;
                gated++;
            end
        end
    endtask

    task automatic run_check(input string tag, input int stall_at, input int stall_len,
                             input bit stall_wr, input logic [31:0] sa, input logic [7:0] sb,
                             output int g);
        bit d;
        run_dut(3000, stall_at, stall_len, stall_wr, sa, sb, -1, g, d);
        bus.startProgram = 1'b0;
        bus.programWrEn  = 1'b0;
        chk({tag, "_done"}, 32'(d), 32'd1);
        chk({tag, "_cycles"}, 32'(g), 32'(exp_cyc + 1));
        foreach (pool[i]) chk({tag, "_mem"}, 32'(dmem(pool[i])), 32'(mrd(pool[i])));
    endtask

    task automatic gen_random();
        int         n, k, a, hs;
        int         patch[$];
        logic [7:0] hb;
        prog.delete();
        n = $urandom_range(3, 10);
        for (int i = 0; i < n; i++) begin
            k = $urandom_range(0, 10);
            a = pool[$urandom_range(0, pool.size() - 1)];
            hb = 8'($urandom_range(0, 63));
            case (k)
                0: prog.push_back(8'h00);
                1: prog.push_back(8'h08);
                2: prog.push_back(8'($urandom_range(9, 254)));
                3, 4: begin
                    prog.push_back(8'h01);
                    prog.push_back(8'($urandom));
                end
                5, 6, 7, 8: begin
                    prog.push_back(8'($urandom_range(2, 5)));
                    prog.push_back(a[7:0]);
                    prog.push_back(a[15:8]);
                    prog.push_back({hb[5:0], a[17:16]});
                end
                default: begin
                    prog.push_back((k == 9) ? 8'h07 : 8'h06);
                    patch.push_back(prog.size());
                    prog.push_back(8'h00);
                    prog.push_back(8'h00);
                    prog.push_back(8'h00);
                end
            endcase
        end
        hs = prog.size();
        prog.push_back(8'hFF);
        foreach (patch[i]) begin
            hb = 8'($urandom_range(0, 63));
            prog[patch[i]]     = hs[7:0];
            prog[patch[i] + 1] = hs[15:8];
            prog[patch[i] + 2] = {hb[5:0], hs[17:16]};
        end
    endtask

    initial begin
        int g;
        bit d;
        reset              = 1'b0;
        bus.startProgram   = 1'b0;
        bus.programWrEn    = 1'b0;
        bus.programAddress = 32'h0;
        bus.programByte    = 8'h00;
        for (int i = 256; i < 264; i++) pool.push_back(i);
        for (int i = MASK - 3; i <= MASK; i++) pool.push_back(i);

        repeat (3) @(negedge clk);
        chk("rst_pc_out", 32'(bus.PC_out), 32'd0);
        chk("rst_pc", 32'(dut.pc_q), 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        reset = 1'b1;

        // Idle: loaded program must not execute without startProgram, nor while the host writes.
        prog = '{8'h01, 8'h05, 8'h04, 8'h00, 8'h01, 8'h00, 8'h03, 8'h01, 8'h01, 8'h00, 8'hFF};
        load(1, 8'h07, 8'h5A);
        repeat (30) @(negedge clk);
        chk("idle_pc_out", 32'(bus.PC_out), 32'd0);
        chk("idle_mem257", 32'(dmem(257)), 32'h5A);
        bus.startProgram   = 1'b1;
        bus.programWrEn    = 1'b1;
        bus.programAddress = 32'h0004_0101;
        bus.programByte    = 8'h33;
        repeat (10) @(negedge clk);
        bus.programWrEn  = 1'b0;
        bus.startProgram = 1'b0;
        chk("hold_state", 32'(dut.state_q), 32'(ST_IDLE));
        chk("oor_mem257", 32'(dmem(257)), 32'h5A);

        run_check("add", -1, 0, 0, 32'h0, 8'h00, g);
        chk("add_result", 32'(dmem(257)), 32'h0C);
        chk("add_cycles_abs", 32'(g), 32'd20);

        prog = '{8'h01, 8'hF0, 8'h04, 8'h00, 8'h01, 8'h00, 8'h03, 8'h01, 8'h01, 8'h00, 8'hFF};
        load(1, 8'h20, 8'h00);
        run_check("addwrap", -1, 0, 0, 32'h0, 8'h00, g);
        chk("addwrap_result", 32'(dmem(257)), 32'h10);

        prog = '{8'h01, 8'h10, 8'h05, 8'h00, 8'h01, 8'h00, 8'h03, 8'h01, 8'h01, 8'h00, 8'hFF};
        load(1, 8'h20, 8'h00);
        run_check("subwrap", -1, 0, 0, 32'h0, 8'h00, g);
        chk("subwrap_result", 32'(dmem(257)), 32'hF0);

        prog = '{8'h01, 8'h00, 8'h07, 8'h0A, 8'h00, 8'h00, 8'h03, 8'h01, 8'h01, 8'h00, 8'hFF};
        load(1, 8'h00, 8'hAA);
        run_check("jz_taken", -1, 0, 0, 32'h0, 8'h00, g);
        chk("jz_taken_result", 32'(dmem(257)), 32'hAA);
        chk("jz_taken_cycles_abs", 32'(g), 32'd13);

        prog = '{8'h01, 8'h01, 8'h07, 8'h0A, 8'h00, 8'h00, 8'h03, 8'h01, 8'h01, 8'h00, 8'hFF};
        load(1, 8'h00, 8'hAA);
        run_check("jz_fall", -1, 0, 0, 32'h0, 8'h00, g);
        chk("jz_fall_result", 32'(dmem(257)), 32'h01);
        chk("jz_fall_cycles_abs", 32'(g), 32'd19);

        prog = '{8'h01, 8'h81, 8'h08, 8'h00, 8'h5C, 8'h03, 8'h01, 8'h01, 8'h00, 8'hFF};
        load(1, 8'h00, 8'h00);
        run_check("shr", -1, 0, 0, 32'h0, 8'h00, g);
        chk("shr_result", 32'(dmem(257)), 32'h40);

        // Stall mid-ADD; the host overwrites the already-latched ADD opcode meanwhile.
        prog = '{8'h01, 8'h05, 8'h04, 8'h00, 8'h01, 8'h00, 8'h03, 8'h01, 8'h01, 8'h00, 8'hFF};
        load(1, 8'h07, 8'h00);
        run_check("stall", 9, 5, 1, 32'h2, 8'hFF, g);
        chk("stall_result", 32'(dmem(257)), 32'h0C);
        chk("stall_cycles_abs", 32'(g), 32'd20);

        // Asynchronous reset in the middle of the ADD operand fetch, then re-run.
        load(1, 8'h07, 8'h5A);
        run_dut(200, -1, 0, 0, 32'h0, 8'h00, 8, g, d);
        chk("abort_pre_state", 32'(dut.state_q), 32'(ST_OPND1));
        #2 reset = 1'b0;
        #1;
        chk("abort_pc_out", 32'(bus.PC_out), 32'd0);
        chk("abort_pc", 32'(dut.pc_q), 32'd0);
        chk("abort_acc", 32'(dut.acc_q), 32'd0);
        chk("abort_state", 32'(dut.state_q), 32'(ST_IDLE));
        bus.startProgram = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        host_wr(32'd257, 8'h00);
        host_end();
        model_run(exp_cyc);
        run_check("rerun", -1, 0, 0, 32'h0, 8'h00, g);
        chk("rerun_result", 32'(dmem(257)), 32'h0C);

        for (int t = 0; t < 12; t++) begin
            gen_random();
            load(0, 8'h00, 8'h00);
            run_check("rand", $urandom_range(0, 25), $urandom_range(1, 6), 1'($urandom_range(0, 1)),
                      32'h0001_0000 + 32'($urandom_range(0, 255)), 8'($urandom), g);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
